signal_generator_multiwave: RTL

Parametrised phase-accumulator tone generator, the next generation of the fixed 128-entry square-wave generator. It produces square/pulse (programmable duty), sawtooth or triangle samples at a configurable sample rate and sample width. Frequency changes are glitch-free, applied only at period boundaries, and a phase-sync input supports multi-voice alignment. It sits between the note sequencer and the mixer/PWM output stage.

---
 rtl/signal_generator_multiwave_pkg.sv | 20 ++
 rtl/signal_generator_multiwave_if.sv | 28 ++
 rtl/signal_generator_multiwave_phase_normalizer.sv | 34 +++
 rtl/signal_generator_multiwave.sv | 112 +++++++++++
 4 files changed

// File: rtl/signal_generator_multiwave_pkg.sv
// Shared types and elaboration helpers for the multi-waveform tone generator.
package signal_gen_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_sel_t;

    // Width of the normalised phase word handed to the waveform shapers.
    localparam int NORM_W = 16;

    // Phase accumulator width. One bit of headroom above clog2(rate) lets the
    // unwrapped sum p + f (at most 1.5 * rate) fit without overflow.
    function automatic int acc_width(input int rate);
        return $clog2(rate) + 1;
    endfunction

endpackage

// File: rtl/signal_generator_multiwave_if.sv
// Control and sample bus between the note sequencer (master) and the tone
// generator (slave).
interface signal_generator_multiwave_if #(
    parameter int FREQ_W   = 14,
    parameter int SAMPLE_W = 8
) ();

    logic                enable;
    logic [FREQ_W-1:0]   freq_in;
    logic [1:0]          wave_sel;
    logic [7:0]          duty;
    logic                phase_sync;
    logic [SAMPLE_W-1:0] out_sample;
    logic                sample_valid;
    logic                period_wrap;
    logic [FREQ_W-1:0]   active_freq;

    modport master (
        output enable, freq_in, wave_sel, duty, phase_sync,
        input  out_sample, sample_valid, period_wrap, active_freq
    );

    modport slave (
        input  enable, freq_in, wave_sel, duty, phase_sync,
        output out_sample, sample_valid, period_wrap, active_freq
    );

endinterface

// File: rtl/signal_generator_multiwave_phase_normalizer.sv
// Maps accumulator phase p (0..SAMPLE_RATE-1) to n = floor(p * 65536 / SAMPLE_RATE)
// without a divider. A reciprocal multiply gives an estimate that is either
// exact or one low; the remainder test then bumps it by one when needed.
module phase_normalizer
    import signal_gen_pkg::*;
#(
    parameter  int SAMPLE_RATE = 32000,
    localparam int PW          = acc_width(SAMPLE_RATE)
) (
    input  logic [PW-1:0]     phase,
    output logic [NORM_W-1:0] norm_phase
);

    // With 2^SHIFT > SAMPLE_RATE, the truncation error of the reciprocal is
    // below one LSB of n for every legal phase.
    localparam int          SHIFT  = PW;
    localparam logic [63:0] RATE64 = 64'(SAMPLE_RATE);
    localparam logic [63:0] RECIP  = (64'd1 << (SHIFT + NORM_W)) / RATE64;

    logic [63:0]       phase_ext;
    logic [63:0]       product;
    logic [63:0]       remainder;
    logic [NORM_W-1:0] estimate;

    // Reciprocal estimate followed by a single-step remainder correction.
    always_comb begin
        phase_ext  = 64'(phase);
        product    = phase_ext * RECIP;
        estimate   = NORM_W'(product >> SHIFT);
        remainder  = (phase_ext << NORM_W) - (64'(estimate) * RATE64);
        norm_phase = (remainder >= RATE64) ? estimate + NORM_W'(1) : estimate;
    end

endmodule

// File: rtl/signal_generator_multiwave.sv
// Phase-accumulator tone generator: square/pulse, saw and triangle voices.
// New frequencies are applied only at period boundaries (or on phase_sync) so
// a running tone never produces a truncated period.
module signal_generator_multiwave
    import signal_gen_pkg::*;
#(
    parameter int SAMPLE_RATE = 32000,
    parameter int FREQ_W      = 14,
    parameter int SAMPLE_W    = 8
) (
    input logic                         CLK_32KHz,
    input logic                         reset,
    signal_generator_multiwave_if.slave bus
);

    localparam int                  PW   = acc_width(SAMPLE_RATE);
    localparam int                  NYQ  = SAMPLE_RATE / 2;
    localparam logic [PW-1:0]       RATE = PW'(SAMPLE_RATE);
    localparam logic [SAMPLE_W-1:0] MAX  = '1;

    logic [PW-1:0]       phase_acc;
    logic [PW-1:0]       phase_sum;
    logic                wrap_now;
    logic                load_active;
    logic [FREQ_W-1:0]   freq_clamped;
    logic [FREQ_W-1:0]   pending_freq;
    logic [FREQ_W-1:0]   active_freq_r;
    logic [NORM_W-1:0]   norm_phase;
    logic [NORM_W-2:0]   tri_fold;
    logic [SAMPLE_W-1:0] wave_value;
    logic [SAMPLE_W-1:0] out_sample_r;
    logic                sample_valid_r;
    logic                period_wrap_r;

    phase_normalizer #(
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_phase_normalizer (
        .phase      (phase_acc),
        .norm_phase (norm_phase)
    );

    // Saturate requests above Nyquist.
    always_comb begin
        freq_clamped = bus.freq_in;
        if (32'(bus.freq_in) > NYQ) begin
            freq_clamped = FREQ_W'(NYQ);
        end
    end

    // Next phase and frequency hand-over condition. A zero active frequency
    // also loads, so the generator starts after reset without waiting for a
    // wrap that would never come.
    always_comb begin
        phase_sum   = phase_acc + PW'(active_freq_r);
        wrap_now    = (phase_sum >= RATE);
        load_active = bus.phase_sync || (bus.enable && wrap_now) || (active_freq_r == '0);
    end

    // Waveform shaping from the pre-update phase.
    always_comb begin
        tri_fold   = norm_phase[NORM_W-1] ? ~norm_phase[NORM_W-2:0] : norm_phase[NORM_W-2:0];
        wave_value = '0;
        case (wave_sel_t'(bus.wave_sel))
            WAVE_SQUARE: wave_value = (norm_phase[15:8] < bus.duty) ? MAX : '0;
            WAVE_SAW:    wave_value = SAMPLE_W'(norm_phase >> (NORM_W - SAMPLE_W));
            WAVE_TRI:    wave_value = SAMPLE_W'(tri_fold >> (NORM_W - 1 - SAMPLE_W));
            default:     wave_value = '0;
        endcase
    end

    // Pending/active frequency pair; the wrap edge itself still uses the old step.
    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            pending_freq  <= '0;
            active_freq_r <= '0;
        end else begin
            pending_freq <= freq_clamped;
            if (load_active) begin
                active_freq_r <= pending_freq;
            end
        end
    end

    // Accumulator and registered sample outputs; phase_sync outranks enable.
    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            phase_acc      <= '0;
            out_sample_r   <= '0;
            sample_valid_r <= 1'b0;
            period_wrap_r  <= 1'b0;
        end else if (bus.phase_sync) begin
            phase_acc      <= '0;
            out_sample_r   <= '0;
            sample_valid_r <= bus.enable;
            period_wrap_r  <= 1'b0;
        end else if (bus.enable) begin
            phase_acc      <= wrap_now ? (phase_sum - RATE) : phase_sum;
            out_sample_r   <= wave_value;
            sample_valid_r <= 1'b1;
            period_wrap_r  <= wrap_now;
        end else begin
            sample_valid_r <= 1'b0;
            period_wrap_r  <= 1'b0;
        end
    end

    assign bus.out_sample   = out_sample_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.period_wrap  = period_wrap_r;
    assign bus.active_freq  = active_freq_r;

endmodule
